farm_mem_arb: RTL and testbench
===============================

FARM_MEM_ARB -- requirements
Module: farm_mem_arb

Interface
REQ-001 The block SHALL have parameter MAX_D_STREAK, default 4, the number of consecutive data grants allowed while fetch waits (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports f_req in 1 and f_addr in 32, the instruction-fetch read request and byte address.
REQ-005 The block SHALL have ports f_gnt out 1, f_rvalid out 1 and f_rdata out 32, the fetch grant pulse, read-data valid pulse and read data.
REQ-006 The block SHALL have ports d_req in 1, d_we in 1, d_be in 4, d_addr in 32 and d_wdata in 32, the load/store request, write enable, byte enables, byte address and write data.
REQ-007 The block SHALL have ports d_gnt out 1, d_rvalid out 1 and d_rdata out 32, the data grant pulse, completion pulse and read data.
REQ-008 The block SHALL have ports m_en out 1, m_we out 1, m_be out 4, m_addr out 32 and m_wdata out 32, the shared single-port memory command.
REQ-009 The block SHALL have ports m_ready in 1, memory accepts the command this cycle, and m_rdata in 32, read data valid the cycle after acceptance.

Function
REQ-010 The FSM SHALL have states IDLE, ISSUE and WAIT, with one access outstanding at most.
REQ-011 In IDLE with any request, the block SHALL assert exactly one gnt combinationally in that cycle, latch the winner's command, and move to ISSUE next cycle.
REQ-012 Arbitration SHALL grant data over fetch, except that fetch wins when f_req=1 and streak==MAX_D_STREAK.
REQ-013 The streak counter SHALL increment on each d_gnt while f_req=1, clear on f_gnt or when f_req=0, and saturate at MAX_D_STREAK.
REQ-014 In ISSUE, m_en SHALL be 1 with the latched command held stable until m_ready=1; reads then go to WAIT and writes go to IDLE with a d_rvalid pulse.
REQ-015 In WAIT, the owner's rvalid SHALL pulse for one cycle with rdata=m_rdata, and the FSM SHALL return to IDLE.
REQ-016 Fetch commands SHALL drive m_we=0 and m_be=4'hF.
REQ-017 m_addr SHALL be {addr[31:2],2'b00}, discarding address bits [1:0].
REQ-018 On a write completion, d_rdata SHALL be 0.
REQ-019 With m_ready=1, a read SHALL complete with gnt at cycle 0, m_en at cycle 1 and rvalid at cycle 2; each m_ready=0 cycle adds one cycle.
REQ-020 Requests asserted in ISSUE or WAIT SHALL receive no grant; requesters hold req and operands stable until gnt.
REQ-021 When not in ISSUE, m_en, m_we, m_be, m_addr and m_wdata SHALL all be 0.
REQ-022 Both requests arriving in the same cycle as rvalid SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-023 On rst=1, the block SHALL enter IDLE, clear the streak, and drive every output to 0, including perf counters when present.
REQ-024 An access interrupted by reset SHALL be abandoned with no rvalid generated, and m_en SHALL be 0 in the cycle after rst is sampled.

Configuration
REQ-025 With FARM_ARB_PERF_EN defined, the block SHALL add 32-bit outputs perf_f_gnt, perf_d_gnt and perf_stall, counting f grants, d grants, and IDLE/ISSUE/WAIT cycles with a req high but no gnt, each wrapping modulo 2^32.
REQ-026 Without FARM_ARB_PERF_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Fetch-only read: f_req=1, f_addr=0x0000_0006, m_ready=1, m_rdata=0x0000_0013 -> f_gnt at cycle 0, m_addr=0x4 with m_en at cycle 1, f_rvalid with f_rdata=0x13 at cycle 2.
REQ-028 Store with wait states: d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF, m_ready low for 2 cycles -> m_en is held 3 cycles with a stable command, then d_rvalid=1 and d_rdata=0.
REQ-029 Simultaneous requests: f_req and d_req both 1 with MAX_D_STREAK=4 -> d wins 4 times, then f wins on the 5th arbitration, and the streak clears.
REQ-030 Reset mid-operation: rst=1 in WAIT -> no rvalid is seen, m_en=0 and the FSM is in IDLE on the next cycle, and the next request is serviced normally.
REQ-031 Perf: with FARM_ARB_PERF_EN defined, run 3 fetch reads and 2 loads back to back -> perf_f_gnt=3 and perf_d_gnt=2, and perf_stall equals the counted waiting cycles.

Source files
------------

// File: rtl/farm_mem_arb.sv
// Fetch/data arbiter in front of a shared single-port memory, one access in flight.
// Optional perf counters are built when FARM_ARB_PERF_EN is defined.
module farm_mem_arb #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
`ifdef FARM_ARB_PERF_EN
    ,
    output logic [31:0] perf_f_gnt,
    output logic [31:0] perf_d_gnt,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e        state_q;
    logic [SW-1:0] streak_q, streak_d;
    logic          own_d_q, we_q, wr_done_q;
    logic [3:0]    be_q;
    logic [31:0]   addr_q, wdata_q;
    logic          d_win, f_win;
    logic [31:0]   sel_addr;
    logic          issue, wait_v, d_rd;

    // Grant decision: data first unless fetch has been starved for MAX_D_STREAK grants.
    always_comb begin
        d_win = 1'b0;
        f_win = 1'b0;
        if (state_q == IDLE && !rst) begin
            d_win = d_req && !(f_req && streak_q == STREAK_MAX);
            f_win = f_req && !d_win;
        end
        sel_addr = d_win ? d_addr : f_addr;
        streak_d = streak_q;
        if (f_win || !f_req) begin
            streak_d = '0;
        end else if (d_win && streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // Reset forces every output low in the same cycle, so an abandoned read never shows rvalid.
    assign issue  = (state_q == ISSUE) && !rst;
    assign wait_v = (state_q == WAIT) && !rst;
    assign d_rd   = wait_v && own_d_q;

    assign f_gnt    = f_win;
    assign d_gnt    = d_win;
    assign f_rvalid = wait_v && !own_d_q;
    assign f_rdata  = f_rvalid ? m_rdata : 32'h0;
    assign d_rvalid = d_rd || (wr_done_q && !rst);
    assign d_rdata  = d_rd ? m_rdata : 32'h0;

    assign m_en    = issue;
    assign m_we    = issue && we_q;
    assign m_be    = issue ? be_q : 4'h0;
    assign m_addr  = issue ? addr_q : 32'h0;
    assign m_wdata = issue ? wdata_q : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wr_done_q <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_win || f_win) begin
                        state_q <= ISSUE;
                        own_d_q <= d_win;
                        we_q    <= d_win && d_we;
                        be_q    <= d_win ? d_be : 4'hF;
                        addr_q  <= sel_addr & 32'hFFFF_FFFC;
                        wdata_q <= (d_win && d_we) ? d_wdata : 32'h0;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        if (we_q) begin
                            state_q   <= IDLE;
                            wr_done_q <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FARM_ARB_PERF_EN
    // Stall = some requester waiting in a cycle where nobody is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_f_gnt <= 32'h0;
            perf_d_gnt <= 32'h0;
            perf_stall <= 32'h0;
        end else begin
            if (f_win) perf_f_gnt <= perf_f_gnt + 32'd1;
            if (d_win) perf_d_gnt <= perf_d_gnt + 32'd1;
            if ((f_req || d_req) && !(f_win || d_win)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_farm_mem_arb.sv
// Directed self-checking bench for farm_mem_arb (perf checks only with FARM_ARB_PERF_EN).
module tb_farm_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_we, m_ready;
    logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;
`ifdef FARM_ARB_PERF_EN
    logic [31:0] perf_f_gnt, perf_d_gnt, perf_stall;
`endif

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    farm_mem_arb #(.MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
`ifdef FARM_ARB_PERF_EN
        , .perf_f_gnt(perf_f_gnt), .perf_d_gnt(perf_d_gnt), .perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Land 2 time units after a rising edge; inputs are driven here, outputs checked 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; m_ready = 1'b0;
        f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; m_rdata = 32'h0;

        // Reset: all outputs low even with both requests raised.
        cyc(); cyc(); #1;
        check("rst_gnt",  32'({f_gnt, d_gnt}), 32'h0);
        check("rst_men",  32'(m_en), 32'h0);
        check("rst_rv",   32'({f_rvalid, d_rvalid}), 32'h0);
        check("rst_addr", m_addr, 32'h0);
        rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
        cyc();

        // Fetch-only read with misaligned address.
        f_req = 1'b1; f_addr = 32'h0000_0006; m_ready = 1'b1; m_rdata = 32'h0000_0013;
        #1;
        check("f_gnt_c0", 32'({f_gnt, d_gnt}), 32'h2);
        check("f_men_c0", 32'(m_en), 32'h0);
        cyc(); f_req = 1'b0; #1;
        check("f_men_c1",  32'(m_en), 32'h1);
        check("f_addr_c1", m_addr, 32'h0000_0004);
        check("f_be_c1",   32'({m_we, m_be}), 32'h0F);
        cyc(); #1;
        check("f_rv_c2",   32'(f_rvalid), 32'h1);
        check("f_rdat_c2", f_rdata, 32'h13);
        check("f_men_c2",  32'(m_en), 32'h0);
        cyc(); #1;
        check("f_rv_c3",   32'(f_rvalid), 32'h0);

        // Store with two wait states; operands scrambled after grant.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; m_ready = 1'b0;
        #1;
        check("st_gnt", 32'({f_gnt, d_gnt}), 32'h1);
        cyc(); d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0; #1;
        check("st_men1",  32'(m_en), 32'h1);
        check("st_cmd1",  32'({m_we, m_be}), 32'h13);
        check("st_addr1", m_addr, 32'h100);
        check("st_wd1",   m_wdata, 32'hDEAD_BEEF);
        cyc(); #1;
        check("st_men2",  32'(m_en), 32'h1);
        check("st_addr2", m_addr, 32'h100);
        cyc(); m_ready = 1'b1; #1;
        check("st_men3",  32'(m_en), 32'h1);
        check("st_wd3",   m_wdata, 32'hDEAD_BEEF);
        cyc(); #1;
        check("st_rv",    32'(d_rvalid), 32'h1);
        check("st_rdat",  d_rdata, 32'h0);
        check("st_men4",  32'(m_en), 32'h0);
        cyc(); #1;
        check("st_rv_end", 32'(d_rvalid), 32'h0);

        // Contention: data wins 4 times, then fetch, then data again after streak clears.
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; f_addr = 32'h300;
        m_ready = 1'b1; m_rdata = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("arb_gnt%0d", i), 32'({f_gnt, d_gnt}), (i == 4) ? 32'h2 : 32'h1);
            cyc(); #1;
            check($sformatf("arb_issue%0d", i), 32'({f_gnt, d_gnt}), 32'h0);
            cyc();
            if (i == 5) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            #1;
            check($sformatf("arb_rv%0d", i), 32'({f_rvalid, d_rvalid}), (i == 4) ? 32'h2 : 32'h1);
            cyc();
        end

        // Reset while waiting for read data: no rvalid, next request proceeds normally.
        f_req = 1'b1; f_addr = 32'h20; m_rdata = 32'h77;
        #1;
        check("rm_gnt", 32'(f_gnt), 32'h1);
        cyc(); f_req = 1'b0; #1;
        check("rm_men", 32'(m_en), 32'h1);
        cyc(); rst = 1'b1; #1;
        check("rm_rv_wait", 32'({f_rvalid, d_rvalid}), 32'h0);
        check("rm_rdat",    f_rdata, 32'h0);
        cyc(); rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; #1;
        check("rm_men_after", 32'(m_en), 32'h0);
        check("rm_rv_after",  32'({f_rvalid, d_rvalid}), 32'h0);
        check("rm_idle_gnt",  32'(d_gnt), 32'h1);
        cyc(); d_req = 1'b0; #1;
        check("rm_men2",  32'(m_en), 32'h1);
        check("rm_addr2", m_addr, 32'h44);
        cyc(); #1;
        check("rm_rv2",   32'(d_rvalid), 32'h1);
        check("rm_rdat2", d_rdata, 32'h77);
        cyc();

`ifdef FARM_ARB_PERF_EN
        // Perf: 3 fetches then 2 loads, requests held through ISSUE/WAIT except the last.
        rst = 1'b1;
        cyc(); #1;
        check("pf_rst", perf_f_gnt | perf_d_gnt | perf_stall, 32'h0);
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            f_req = (t < 3); d_req = (t >= 3); d_we = 1'b0;
            #1;
            check($sformatf("pf_gnt%0d", t), 32'({f_gnt, d_gnt}), (t < 3) ? 32'h2 : 32'h1);
            cyc();
            if (t == 4) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            cyc(); cyc();
        end
        #1;
        check("pf_f",     perf_f_gnt, 32'd3);
        check("pf_d",     perf_d_gnt, 32'd2);
        check("pf_stall", perf_stall, 32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
